// File: rtl/register_file.sv
// Parametrised register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero register 0 and optional write-to-read bypass.
module register_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic zero_a, zero_b;
    logic hit_a, hit_b;

    // clr beats a write; register 0 is forced constant so its flops are swept away
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clr) begin
                mem_d[i] = '0;
            end else if (we && (waddr == AW'(i))) begin
                mem_d[i] = wdata;
            end
            if (ZERO_REG && (i == 0)) begin
                mem_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Bypass is gated by n_reset so reads stay zero while reset is held
    always_comb begin
        zero_a = ZERO_REG && (raddr_a == '0);
        zero_b = ZERO_REG && (raddr_b == '0);
        hit_a  = BYPASS && n_reset && we && !clr && (raddr_a == waddr);
        hit_b  = BYPASS && n_reset && we && !clr && (raddr_b == waddr);

        if (zero_a) begin
            rdata_a = '0;
        end else if (hit_a) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem_q[raddr_a];
        end

        if (zero_b) begin
            rdata_b = '0;
        end else if (hit_b) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem_q[raddr_b];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three instances cover plain 8x8 storage,
// zero-register plus bypass, and a 16-bit x 32-word configuration.
`timescale 1ns/100ps
module tb_register_file;

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       clr;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [7:0] a1;
        logic [7:0] b1;
    } vec_t;

    localparam int NV = 21;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       we, clr;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;

    logic        we2, clr2;
    logic [4:0]  waddr2, raddr_a2, raddr_b2;
    logic [15:0] wdata2;
    logic [15:0] rd_a2, rd_b2;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    vec_t        vt[NV];

    always #5 clk = ~clk;

    // dut0: plain storage, register 0 writable, no bypass
    register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut0 (
        .clk(clk), .n_reset(n_reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a0), .rdata_b(rd_b0)
    );

    // dut1: hardwired zero register with bypass
    register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (
        .clk(clk), .n_reset(n_reset), .we(we), .waddr(waddr), .wdata(wdata), .clr(clr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a1), .rdata_b(rd_b1)
    );

    register_file #(.WIDTH(16), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut2 (
        .clk(clk), .n_reset(n_reset), .we(we2), .waddr(waddr2), .wdata(wdata2), .clr(clr2),
        .raddr_a(raddr_a2), .raddr_b(raddr_b2), .rdata_a(rd_a2), .rdata_b(rd_b2)
    );

    function automatic vec_t mk(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                                input logic c, input logic [2:0] ra, input logic [2:0] rb,
                                input logic [7:0] a0, input logic [7:0] b0,
                                input logic [7:0] a1, input logic [7:0] b1);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.clr = c; v.ra = ra; v.rb = rb;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        return v;
    endfunction

    task automatic expect_val(input logic [15:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] act);
        logic [15:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: got %h, scoreboard queue empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    initial begin
        // Expected values are the pre-edge reads: dut0 (no bypass, r0 writable), dut1 (bypass, r0 = 0)
        vt[0]  = mk(1, 1, 8'h3C, 0, 1, 7, 8'h00, 8'h00, 8'h3C, 8'h00);
        vt[1]  = mk(1, 7, 8'hFF, 0, 1, 7, 8'h3C, 8'h00, 8'h3C, 8'hFF);
        vt[2]  = mk(0, 0, 8'h00, 0, 1, 7, 8'h3C, 8'hFF, 8'h3C, 8'hFF);
        vt[3]  = mk(1, 0, 8'h55, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[4]  = mk(0, 0, 8'h00, 0, 0, 1, 8'h55, 8'h3C, 8'h00, 8'h3C);
        vt[5]  = mk(1, 2, 8'h81, 0, 2, 2, 8'h00, 8'h00, 8'h81, 8'h81);
        vt[6]  = mk(1, 2, 8'h42, 1, 2, 7, 8'h81, 8'hFF, 8'h81, 8'hFF);
        vt[7]  = mk(0, 0, 8'h00, 0, 2, 7, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[8]  = mk(1, 1, 8'h11, 0, 1, 0, 8'h00, 8'h00, 8'h11, 8'h00);
        vt[9]  = mk(1, 2, 8'h22, 0, 2, 1, 8'h00, 8'h11, 8'h22, 8'h11);
        vt[10] = mk(1, 3, 8'h33, 0, 3, 2, 8'h00, 8'h22, 8'h33, 8'h22);
        vt[11] = mk(1, 4, 8'h44, 0, 4, 3, 8'h00, 8'h33, 8'h44, 8'h33);
        vt[12] = mk(1, 5, 8'h55, 0, 5, 4, 8'h00, 8'h44, 8'h55, 8'h44);
        vt[13] = mk(1, 6, 8'h66, 0, 6, 5, 8'h00, 8'h55, 8'h66, 8'h55);
        vt[14] = mk(1, 7, 8'h77, 0, 7, 6, 8'h00, 8'h66, 8'h77, 8'h66);
        vt[15] = mk(1, 4, 8'h99, 1, 4, 7, 8'h44, 8'h77, 8'h44, 8'h77);
        vt[16] = mk(0, 0, 8'h00, 0, 4, 7, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[17] = mk(0, 0, 8'h00, 0, 1, 3, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[18] = mk(0, 0, 8'h00, 0, 5, 6, 8'h00, 8'h00, 8'h00, 8'h00);
        vt[19] = mk(1, 3, 8'hA5, 0, 3, 3, 8'h00, 8'h00, 8'hA5, 8'hA5);
        vt[20] = mk(0, 0, 8'h00, 0, 3, 0, 8'hA5, 8'h00, 8'hA5, 8'h00);

        // Reset held with a bypassable write pending: every read must be zero
        n_reset = 1'b0;
        we = 1'b1; waddr = 3'd2; wdata = 8'hFF; clr = 1'b0; raddr_a = 3'd2; raddr_b = 3'd2;
        we2 = 1'b0; waddr2 = '0; wdata2 = '0; clr2 = 1'b0; raddr_a2 = 5'd31; raddr_b2 = 5'd30;
        #3;
        expect_val(16'h0); check("reset d0 a", 16'(rd_a0));
        expect_val(16'h0); check("reset d1 a", 16'(rd_a1));
        expect_val(16'h0); check("reset d1 b", 16'(rd_b1));
        expect_val(16'h0); check("reset d2 a", rd_a2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
        we = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd; clr = vt[i].clr;
            raddr_a = vt[i].ra; raddr_b = vt[i].rb;
            expect_val(16'(vt[i].a0)); expect_val(16'(vt[i].b0));
            expect_val(16'(vt[i].a1)); expect_val(16'(vt[i].b1));
            @(negedge clk);
            check($sformatf("v%0d d0 a", i), 16'(rd_a0));
            check($sformatf("v%0d d0 b", i), 16'(rd_b0));
            check($sformatf("v%0d d1 a", i), 16'(rd_a1));
            check($sformatf("v%0d d1 b", i), 16'(rd_b1));
        end

        // Mid-cycle reset pulse after r3 = 0xA5
        @(posedge clk); #1;
        we = 1'b1; waddr = 3'd3; wdata = 8'h5A; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        expect_val(16'hA5); check("pre-rst d0 r3", 16'(rd_a0));
        expect_val(16'h5A); check("pre-rst d1 bypass", 16'(rd_a1));
        n_reset = 1'b0;
        #1;
        expect_val(16'h0); check("rst async d0 r3", 16'(rd_a0));
        expect_val(16'h0); check("rst async d1 a", 16'(rd_a1));
        expect_val(16'h0); check("rst async d1 b", 16'(rd_b1));
        @(posedge clk); #1;
        expect_val(16'h0); check("rst write ignored d0", 16'(rd_a0));
        expect_val(16'h0); check("rst write ignored d1", 16'(rd_a1));
        @(negedge clk);
        n_reset = 1'b1;
        we = 1'b0;
        for (int r = 0; r < 4; r++) begin
            raddr_a = 3'(r); raddr_b = 3'(r + 4);
            #1;
            expect_val(16'h0); check($sformatf("post-rst d0 r%0d", r), 16'(rd_a0));
            expect_val(16'h0); check($sformatf("post-rst d0 r%0d", r + 4), 16'(rd_b0));
            expect_val(16'h0); check($sformatf("post-rst d1 r%0d", r), 16'(rd_a1));
            expect_val(16'h0); check($sformatf("post-rst d1 r%0d", r + 4), 16'(rd_b1));
        end

        // First write after release is honoured at the next edge
        @(posedge clk); #1;
        we = 1'b1; waddr = 3'd6; wdata = 8'hC3; raddr_a = 3'd6; raddr_b = 3'd0;
        @(negedge clk);
        expect_val(16'h00); check("first wr d0 same cycle", 16'(rd_a0));
        expect_val(16'hC3); check("first wr d1 bypass", 16'(rd_a1));
        @(posedge clk); #1;
        we = 1'b0;
        @(negedge clk);
        expect_val(16'hC3); check("first wr d0 after", 16'(rd_a0));
        expect_val(16'hC3); check("first wr d1 after", 16'(rd_a1));

        // 16-bit x 32-word configuration
        @(posedge clk); #1;
        we2 = 1'b1; waddr2 = 5'd31; wdata2 = 16'hBEEF; raddr_a2 = 5'd30; raddr_b2 = 5'd31;
        @(negedge clk);
        expect_val(16'h0000); check("d2 r31 same cycle", rd_b2);
        @(posedge clk); #1;
        waddr2 = 5'd0; wdata2 = 16'hFFFF;
        @(negedge clk);
        expect_val(16'hBEEF); check("d2 r31 after", rd_b2);
        expect_val(16'h0000); check("d2 r30 unchanged", rd_a2);
        @(posedge clk); #1;
        we2 = 1'b0; raddr_a2 = 5'd0;
        @(negedge clk);
        expect_val(16'h0000); check("d2 r0 hardwired", rd_a2);
        expect_val(16'hBEEF); check("d2 r31 held", rd_b2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file for the picoMIPS datapath, generalising the single enabled register into DEPTH words of WIDTH bits. It provides one synchronous write port, two independent combinational read ports, an optional hardwired-zero register, a synchronous clear and an optional write-to-read bypass. It sits between instruction decode and the ALU: decode drives the read addresses, and the writeback path drives the write port.

## Interface
- WIDTH, 8: bits per register.
- DEPTH, 8: number of registers. Must be a power of two and at least 2. Address width AW = $clog2(DEPTH), a derived localparam.
- ZERO_REG, 1: when 1, register 0 always reads as 0 and writes to it are discarded.
- BYPASS, 0: when 1, a read of the address being written in the same cycle returns wdata instead of the stored value.

Ports:
- clk  input  1  rising-edge clock.
- n_reset  input  1  asynchronous, active-low reset.
- we  input  1  write enable, sampled on the rising clk edge.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- clr  input  1  synchronous clear of all registers.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- rdata_a  output  WIDTH  read data, port A.
- rdata_b  output  WIDTH  read data, port B.

## Operation
- **Storage.** DEPTH × WIDTH flip-flops. No memory-block inference is required.
- **Reset.** n_reset low asynchronously forces every register to 0. While reset is held, rdata_a and rdata_b read 0 for every address, regardless of BYPASS.
- **Priority at a rising edge** with n_reset high:
  1. clr = 1: all registers become 0, and any write in that cycle is discarded.
  2. Otherwise, if we = 1 (and not ZERO_REG with waddr = 0): mem[waddr] ← wdata.
  3. Otherwise: all registers hold.
- **Read.** rdata_x = mem[raddr_x] combinationally. When ZERO_REG = 1 and raddr_x = 0, rdata_x = 0.
- **Bypass (BYPASS = 1).** rdata_x = wdata when all of the following hold:
  - we = 1,
  - clr = 0,
  - raddr_x = waddr,
  - the address is not the hardwired zero register.

  The zero-register rule takes precedence over bypass. clr suppresses bypass.
- **Independent ports.** Both read ports may address the same register and then return identical data.
- **Widths.** No arithmetic is performed. Addresses are full-range because DEPTH is a power of two, so no out-of-range case exists.

## Timing
- **Write latency.** Data written at edge N is visible on the read ports after edge N, i.e. in cycle N+1, with BYPASS = 0.
- **Bypass latency.** With BYPASS = 1, the data is visible combinationally in the write cycle itself, before edge N.
- **Read latency.** Zero cycles (combinational from address and storage).
- **clr timing.** clr asserted in cycle N gives all-zero reads from cycle N+1. A write requested in cycle N is lost.
- **Reset mid-operation.** Asserting n_reset asynchronously discards all contents immediately. A write at an edge coincident with reset assertion does not take effect.
- **Reset release.** Release of n_reset must be synchronised externally to clk. The first write is honoured at the first edge after release.
- **Register 0.** With ZERO_REG = 1, register 0 is never written, so no flip-flops are required for it.

## Test plan
- **Reset:** pulse n_reset low mid-cycle after writing 0xA5 to r3 → rdata_a reads 0 for raddr_a = 3 immediately, before the next edge; all eight registers read 0 afterwards.
- **Write/read:** write r1 = 0x3C and r7 = 0xFF on consecutive edges, then set raddr_a = 1, raddr_b = 7 → rdata_a = 0x3C, rdata_b = 0xFF; in the cycle of the r1 write with BYPASS = 0, rdata_a still shows the old value 0x00.
- **Zero register (ZERO_REG = 1):** we = 1, waddr = 0, wdata = 0x55, then read raddr_a = 0 → 0x00 in the write cycle (including with BYPASS = 1) and after it.
- **Bypass (BYPASS = 1):** we = 1, waddr = 2, wdata = 0x81, raddr_a = raddr_b = 2 in the same cycle → both ports show 0x81 before the edge.
- **Clear priority:** fill r1..r7 with 0x11..0x77, then assert clr = 1 together with we = 1, waddr = 4, wdata = 0x99 → after the edge all registers, including r4, read 0x00.
- **Parametrisation:** re-run the write/read scenario with WIDTH = 16, DEPTH = 32, writing 0xBEEF to r31 → rdata_b = 0xBEEF with raddr_b = 31, and r30 is unchanged at 0x0000.
